fpnew_pipe_share_ctrl: RTL

Shares one pipelined FP datapath (an fpnew pipe-out style elastic register chain) between NumReq independent requesters.
- Round-robin arbitration on the issue side, with a grant lock that keeps the issue interface stable while stalled.
- Attaches a requester ID as sideband that travels through the shared pipeline, and routes returning results back to the originating requester by that ID.
- Bounds outstanding operations with an in-flight credit counter.
- Sits between the per-lane issue logic and the shared unit.

---
 rtl/fpnew_pkg.sv | 22 ++
 rtl/fpnew_rr_arb.sv | 89 ++++++++
 rtl/fpnew_pipe_share_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - shared FP types and elaboration helpers
//
// Contents:
//   status_t    - IEEE exception flags returned alongside each FP result
//   clog2_min1  - ceil(log2(n)), never less than 1, for sizing ID and counter fields

package fpnew_pkg;

    typedef struct packed {
        logic NV; // invalid operation
        logic DZ; // divide by zero
        logic OF; // overflow
        logic UF; // underflow
        logic NX; // inexact
    } status_t;

    // A single requester or a single credit still needs a one-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_arb.sv
// rtl/fpnew_rr_arb.sv - round-robin arbiter with stall lock for a shared issue port
//
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   flush_i        drops the lock; the rr pointer is kept
//   req_i          per-input request
//   gnt_ready_i    the current grant was accepted downstream this cycle
//   lock_i         the current grant is offered but stalled; freeze it
//   gnt_o          one-hot grant, qualified by gnt_valid_o
//   gnt_id_o       granted input index (0 when nothing is requesting)
//   gnt_valid_o    the granted input is requesting

module fpnew_rr_arb import fpnew_pkg::*; #(
    parameter  int unsigned NumIn = 4,
    localparam int unsigned IdW   = clog2_min1(NumIn)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [NumIn-1:0] req_i,
    input  logic             gnt_ready_i,
    input  logic             lock_i,
    output logic [NumIn-1:0] gnt_o,
    output logic [IdW-1:0]   gnt_id_o,
    output logic             gnt_valid_o
);

    logic [IdW-1:0] ptr_q, ptr_d;
    logic           lock_q, lock_d;
    logic [IdW-1:0] locked_id_q, locked_id_d;

    logic [IdW-1:0] sel_id;
    logic [IdW-1:0] idx;
    logic           found;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        sel_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < NumIn; k++) begin
            idx = IdW'((int'(ptr_q) + k) % NumIn);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                sel_id = idx;
            end
        end
    end

    // While locked the stalled grant is re-offered unchanged, even if a
    // higher-priority requester has appeared in the meantime.
    assign gnt_id_o    = lock_q ? locked_id_q : sel_id;
    assign gnt_valid_o = lock_q ? req_i[locked_id_q] : found;

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            gnt_o[i] = gnt_valid_o & (gnt_id_o == IdW'(i));
        end
    end

    always_comb begin
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        ptr_d       = ptr_q;
        if (flush_i || gnt_ready_i) begin
            lock_d = 1'b0;
        end else if (lock_i) begin
            lock_d      = 1'b1;
            locked_id_d = gnt_id_o;
        end
        if (gnt_ready_i) begin
            ptr_d = IdW'((int'(gnt_id_o) + 1) % NumIn);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
        end
    end

endmodule

// File: rtl/fpnew_pipe_share_ctrl.sv
// rtl/fpnew_pipe_share_ctrl.sv - shares one pipelined FP unit between several requesters
//
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   flush_i           sync flush of credits and grant lock (also fed to the shared unit)
//   in_*              per-requester issue handshake with payload and tag
//   pipe_*_o / _i     issue side towards the shared unit (valid/ready/data/tag/id)
//   pipe_valid_i ...  result side from the shared unit, routed back by pipe_id_i
//   out_*             per-requester result handshake; payload broadcast to all
//   busy_o            operations in flight or a request pending

module fpnew_pipe_share_ctrl import fpnew_pkg::*; #(
    parameter  int unsigned NumReq      = 4,
    parameter  int unsigned Width       = 32,
    parameter  type         TagType     = logic,
    parameter  int unsigned MaxInFlight = 4,
    localparam int unsigned IdWidth     = clog2_min1(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NumReq-1:0]            in_valid_i,
    output logic [NumReq-1:0]            in_ready_o,
    input  logic [NumReq-1:0][Width-1:0] in_data_i,
    input  TagType [NumReq-1:0]          in_tag_i,
    output logic                         pipe_valid_o,
    input  logic                         pipe_ready_i,
    output logic [Width-1:0]             pipe_data_o,
    output TagType                       pipe_tag_o,
    output logic [IdWidth-1:0]           pipe_id_o,
    input  logic                         pipe_valid_i,
    output logic                         pipe_ready_o,
    input  logic [Width-1:0]             pipe_result_i,
    input  status_t                      pipe_status_i,
    input  TagType                       pipe_tag_i,
    input  logic [IdWidth-1:0]           pipe_id_i,
    output logic [NumReq-1:0]            out_valid_o,
    input  logic [NumReq-1:0]            out_ready_i,
    output logic [Width-1:0]             out_result_o,
    output status_t                      out_status_o,
    output TagType                       out_tag_o,
    output logic                         busy_o
);

    localparam int unsigned CntWidth = clog2_min1(MaxInFlight + 1);

    logic [NumReq-1:0]   gnt;
    logic [IdWidth-1:0]  gnt_id;
    logic                gnt_valid;
    logic                can_issue;
    logic                issue_hs;
    logic                ret_hs;
    logic                id_ok;
    logic [CntWidth-1:0] count_q, count_d;

    // ---------------- issue side ----------------

    assign can_issue = (count_q < CntWidth'(MaxInFlight));

    // Flush suppresses issue so no credit is taken in the cycle it is cleared.
    assign pipe_valid_o = can_issue & gnt_valid & ~flush_i;
    assign issue_hs     = pipe_valid_o & pipe_ready_i;
    assign in_ready_o   = gnt & {NumReq{issue_hs}};

    // gnt_id is 0 when idle, so the payload rests on requester 0.
    assign pipe_data_o = in_data_i[gnt_id];
    assign pipe_tag_o  = in_tag_i[gnt_id];
    assign pipe_id_o   = gnt_id;

    fpnew_rr_arb #(
        .NumIn (NumReq)
    ) i_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_i       (in_valid_i),
        .gnt_ready_i (issue_hs),
        .lock_i      (pipe_valid_o & ~pipe_ready_i),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    // ---------------- return side ----------------

    // An ID that matches no requester is accepted and discarded so a corrupt
    // sideband cannot wedge the shared pipeline.
    always_comb begin
        out_valid_o  = '0;
        pipe_ready_o = 1'b1;
        id_ok        = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (pipe_id_i == IdWidth'(i)) begin
                id_ok          = 1'b1;
                pipe_ready_o   = out_ready_i[i];
                out_valid_o[i] = pipe_valid_i;
            end
        end
    end

    assign out_result_o = pipe_result_i;
    assign out_status_o = pipe_status_i;
    assign out_tag_o    = pipe_tag_i;

    // Results arriving during a flush belong to the discarded epoch.
    assign ret_hs = pipe_valid_i & pipe_ready_o & ~flush_i;

    // ---------------- credit counter ----------------

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (issue_hs && !ret_hs) begin
            count_d = count_q + CntWidth'(1);
        end else if (!issue_hs && ret_hs && (count_q != '0)) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o = (count_q != '0) | (|in_valid_i);

`ifndef SYNTHESIS
    a_no_return_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ret_hs |-> (count_q != '0));
    a_return_id_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pipe_valid_i |-> id_ok);
`endif

endmodule
